// File: rtl/axi_xbar_pkg.sv
// Shared constants and types for the crossbar read-data return path.
// Slave indices, RID tag values and the return-router state encoding live here.
package axi_xbar_pkg;

  localparam int NS    = 7;
  localparam int IDX_W = 3;
  localparam int SIDW  = 8;
  localparam int MIDW  = 4;
  localparam int DW    = 32;
  localparam int RW    = 2;
  localparam int CNT_W = 8;

  localparam logic [3:0] TAG_M0 = 4'b0001;
  localparam logic [3:0] TAG_M1 = 4'b0010;

  localparam logic [IDX_W-1:0] SLV_ROM  = 3'd0;
  localparam logic [IDX_W-1:0] SLV_IM   = 3'd1;
  localparam logic [IDX_W-1:0] SLV_DM   = 3'd2;
  localparam logic [IDX_W-1:0] SLV_SC   = 3'd3;
  localparam logic [IDX_W-1:0] SLV_WDT  = 3'd4;
  localparam logic [IDX_W-1:0] SLV_DRAM = 3'd5;
  localparam logic [IDX_W-1:0] SLV_SD   = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Slave index successor, wrapping at NS.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NS - 1)) begin
      next_idx = '0;
    end else begin
      next_idx = idx + 1'b1;
    end
  endfunction

endpackage

// File: rtl/axi_r_return_router_rr_arbiter.sv
// Combinational round-robin picker: first requesting slave at or after ptr_i.
// The owning FSM registers the result and advances the pointer.
module rr_arbiter
  import axi_xbar_pkg::*;
(
  input  logic [NS-1:0]    req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_req_o
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    idx       = ptr_i;
    for (int k = 0; k < NS; k++) begin
      if (!any_req_o && req_i[idx]) begin
        grant_o   = idx;
        any_req_o = 1'b1;
      end
      idx = next_idx(idx);
    end
  end

endmodule

// File: rtl/axi_r_return_router.sv
// AXI R-channel return router: locks onto one slave per burst (round robin)
// and steers each beat to M0/M1 by the RID master tag, stripping the tag.
module axi_r_return_router
  import axi_xbar_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NS*SIDW-1:0] RID_S,
  input  logic [NS*DW-1:0]   RDATA_S,
  input  logic [NS*RW-1:0]   RRESP_S,
  input  logic [NS-1:0]      RLAST_S,
  input  logic [NS-1:0]      RVALID_S,
  output logic [NS-1:0]      RREADY_S,
  output logic [MIDW-1:0]    RID_M0,
  output logic [DW-1:0]      RDATA_M0,
  output logic [RW-1:0]      RRESP_M0,
  output logic               RLAST_M0,
  output logic               RVALID_M0,
  input  logic               RREADY_M0,
  output logic [MIDW-1:0]    RID_M1,
  output logic [DW-1:0]      RDATA_M1,
  output logic [RW-1:0]      RRESP_M1,
  output logic               RLAST_M1,
  output logic               RVALID_M1,
  input  logic               RREADY_M1,
  output logic               busy,
  output logic [CNT_W-1:0]   beat_cnt
);

  // Handshake rule on every port: a beat moves on a clock edge where valid and
  // ready are both high; valid and payload stay stable until that edge.

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic [IDX_W-1:0]  arb_grant;
  logic              arb_any;

  logic [SIDW-1:0]   rid_g;
  logic [DW-1:0]     data_g;
  logic [RW-1:0]     resp_g;
  logic              last_g;
  logic              valid_g;
  logic              ready_g;
  logic              hs;

  rr_arbiter u_arb (
    .req_i     (RVALID_S),
    .ptr_i     (rr_ptr_q),
    .grant_o   (arb_grant),
    .any_req_o (arb_any)
  );

  always_comb begin
    rid_g   = RID_S[int'(grant_q)*SIDW +: SIDW];
    data_g  = RDATA_S[int'(grant_q)*DW +: DW];
    resp_g  = RRESP_S[int'(grant_q)*RW +: RW];
    last_g  = RLAST_S[grant_q];
    valid_g = RVALID_S[grant_q];
  end

  // Routing is decided from the live RID each beat; nothing is buffered.
  always_comb begin
    RID_M0    = '0;
    RDATA_M0  = '0;
    RRESP_M0  = '0;
    RLAST_M0  = 1'b0;
    RVALID_M0 = 1'b0;
    RID_M1    = '0;
    RDATA_M1  = '0;
    RRESP_M1  = '0;
    RLAST_M1  = 1'b0;
    RVALID_M1 = 1'b0;
    RREADY_S  = '0;
    ready_g   = 1'b0;
    if (state_q == BUSY) begin
      if (rid_g[7:4] == TAG_M0) begin
        RID_M0    = rid_g[MIDW-1:0];
        RDATA_M0  = data_g;
        RRESP_M0  = resp_g;
        RLAST_M0  = last_g;
        RVALID_M0 = valid_g;
        ready_g   = RREADY_M0;
      end else if (rid_g[7:4] == TAG_M1) begin
        RID_M1    = rid_g[MIDW-1:0];
        RDATA_M1  = data_g;
        RRESP_M1  = resp_g;
        RLAST_M1  = last_g;
        RVALID_M1 = valid_g;
        ready_g   = RREADY_M1;
      end else begin
        // Unroutable tag: drain the burst so the slave cannot wedge the path.
        ready_g = 1'b1;
      end
      RREADY_S[grant_q] = ready_g;
    end
  end

  assign hs = (state_q == BUSY) && valid_g && ready_g;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (hs) begin
          if (beat_cnt_q != {CNT_W{1'b1}}) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
          if (last_g) begin
            state_d    = IDLE;
            rr_ptr_d   = next_idx(grant_q);
            beat_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign busy     = (state_q == BUSY);
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_axi_r_return_router.sv
// Bench for axi_r_return_router: queued slave models, master-side scoreboard
// monitor, and directed bursts covering reset, routing, backpressure and arbitration.
module tb_axi_r_return_router;
  import axi_xbar_pkg::*;

  logic              clk;
  logic              rst;
  logic [NS*8-1:0]   RID_S;
  logic [NS*32-1:0]  RDATA_S;
  logic [NS*2-1:0]   RRESP_S;
  logic [NS-1:0]     RLAST_S;
  logic [NS-1:0]     RVALID_S;
  logic [NS-1:0]     RREADY_S;
  logic [3:0]        RID_M0, RID_M1;
  logic [31:0]       RDATA_M0, RDATA_M1;
  logic [1:0]        RRESP_M0, RRESP_M1;
  logic              RLAST_M0, RLAST_M1;
  logic              RVALID_M0, RVALID_M1;
  logic              RREADY_M0, RREADY_M1;
  logic              busy;
  logic [7:0]        beat_cnt;

  axi_r_return_router dut (
    .clk(clk), .rst(rst),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .busy(busy), .beat_cnt(beat_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int hs_cnt  = 0;
  logic rdy_toggle = 1'b0;

  // slave beat = {rid8, data32, resp2, last1}; master beat = {rid4, data32, resp2, last1}
  logic [42:0] slv_q [NS][$];
  logic [38:0] exp_m0 [$];
  logic [38:0] exp_m1 [$];
  int          order_q [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_total++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic drive_heads();
    for (int i = 0; i < NS; i++) begin
      if (slv_q[i].size() > 0) begin
        {RID_S[8*i +: 8], RDATA_S[32*i +: 32], RRESP_S[2*i +: 2], RLAST_S[i]} = slv_q[i][0];
        RVALID_S[i] = 1'b1;
      end else begin
        RID_S[8*i +: 8]    = '0;
        RDATA_S[32*i +: 32] = '0;
        RRESP_S[2*i +: 2]  = '0;
        RLAST_S[i]         = 1'b0;
        RVALID_S[i]        = 1'b0;
      end
    end
  endtask

  // Queue n beats on slave s; the first n_exp are expected at the tagged master.
  task automatic load(input int s, input logic [7:0] rid, input int n,
                      input logic [31:0] base, input logic [1:0] resp, input int n_exp);
    for (int k = 0; k < n; k++) begin
      slv_q[s].push_back({rid, base + 32'(k), resp, (k == n - 1)});
      if (k < n_exp) begin
        if (rid[7:4] == 4'b0001) exp_m0.push_back({rid[3:0], base + 32'(k), resp, (k == n - 1)});
        if (rid[7:4] == 4'b0010) exp_m1.push_back({rid[3:0], base + 32'(k), resp, (k == n - 1)});
      end
    end
    drive_heads();
  endtask

  task automatic clear_slaves();
    for (int i = 0; i < NS; i++) slv_q[i].delete();
    drive_heads();
  endtask

  task automatic wait_hs(input int target, input string nm);
    bit done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      if (hs_cnt >= target) done = 1'b1;
      else begin
        @(posedge clk); #2;
      end
    end
    if (!done) begin
      n_total++; n_bad++;
      $display("FAIL %s_timeout actual=%0d expected=%0d", nm, hs_cnt, target);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(posedge clk); #2;
      done = !busy && (RVALID_S == '0);
    end
    if (!done) begin
      n_total++; n_bad++;
      $display("FAIL %s_idle_timeout actual=%0b expected=0", nm, busy);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_slaves();
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_rready_s", RREADY_S, 7'h0);
    check("rst_rvalid_m", {RVALID_M0, RVALID_M1}, 2'b00);
    check("rst_data_m", {RDATA_M0, RDATA_M1}, 64'h0);
    check("rst_beat_cnt", beat_cnt, 8'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  // driver: handshakes are sampled at negedge (inputs are stable until the next
  // edge), beats retired and heads re-presented just after the active edge
  initial begin : slave_driver
    logic [NS-1:0] hs;
    forever begin
      @(negedge clk);
      hs = rst ? (RVALID_S & RREADY_S) : '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (hs[i] && slv_q[i].size() > 0) begin
          void'(slv_q[i].pop_front());
          hs_cnt++;
          order_q.push_back(i);
        end
      end
      drive_heads();
      RREADY_M0 = rdy_toggle ? ~RREADY_M0 : 1'b1;
    end
  end

  // monitor / scoreboard
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rready_s_onehot0", $onehot0(RREADY_S), 1'b1);
        if (RVALID_M0) begin
          if (exp_m0.size() == 0) begin
            check("m0_unexpected_valid", RVALID_M0, 1'b0);
          end else begin
            check("m0_beat", {RID_M0, RDATA_M0, RRESP_M0, RLAST_M0}, exp_m0[0]);
            check("m0_rready_mirror", |RREADY_S, RREADY_M0);
            if (RREADY_M0) void'(exp_m0.pop_front());
          end
        end
        if (RVALID_M1) begin
          if (exp_m1.size() == 0) begin
            check("m1_unexpected_valid", RVALID_M1, 1'b0);
          end else begin
            check("m1_beat", {RID_M1, RDATA_M1, RRESP_M1, RLAST_M1}, exp_m1[0]);
            check("m1_rready_mirror", |RREADY_S, RREADY_M1);
            if (RREADY_M1) void'(exp_m1.pop_front());
          end
        end
      end
    end
  end

  initial begin : stimulus
    int base;
    int exp_order [4];
    rst = 1'b0;
    RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = '0; RVALID_S = '0;
    RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
    @(posedge clk);
    do_reset();
    @(posedge clk); #2;
    check("post_reset_busy", busy, 1'b0);
    check("post_reset_cnt", beat_cnt, 8'h0);

    // reset mid-burst: DM, 4 beats, reset after the second handshake
    base = hs_cnt;
    load(SLV_DM, 8'h1A, 4, 32'h0000_D000, 2'b00, 2);
    wait_hs(base + 2, "midrst");
    check("midrst_cnt_before", beat_cnt, 8'd2);
    check("midrst_busy_before", busy, 1'b1);
    do_reset();
    @(posedge clk); #2;
    check("midrst_busy_after", busy, 1'b0);
    check("midrst_cnt_after", beat_cnt, 8'h0);
    check("midrst_exp_drained", exp_m0.size(), 0);

    // single burst from IM, RID 8'h13 -> M0 with RID 4'h3
    base = hs_cnt;
    load(SLV_IM, 8'h13, 4, 32'hA0, 2'b00, 4);
    for (int k = 1; k <= 4; k++) begin
      wait_hs(base + k, "single");
      check("single_beat_cnt", beat_cnt, (k == 4) ? 8'd0 : 8'(k));
    end
    check("single_idle", busy, 1'b0);

    // backpressure: RREADY_M0 toggles every cycle
    wait_idle("bp_pre");
    rdy_toggle = 1'b1;
    base = hs_cnt;
    load(SLV_IM, 8'h13, 4, 32'hA0, 2'b01, 4);
    wait_hs(base + 4, "bp");
    check("bp_handshakes", hs_cnt - base, 4);
    wait_idle("bp");
    rdy_toggle = 1'b0;

    // round robin from rr_ptr=0: ROM, DM, DRAM then ROM again
    @(posedge clk);
    do_reset();
    @(posedge clk); #2;
    order_q.delete();
    base = hs_cnt;
    load(SLV_ROM, 8'h11, 1, 32'hB0, 2'b00, 1);
    load(SLV_DM, 8'h12, 1, 32'hB2, 2'b00, 1);
    load(SLV_DRAM, 8'h15, 1, 32'hB5, 2'b00, 1);
    wait_hs(base + 3, "rr");
    wait_idle("rr");
    load(SLV_ROM, 8'h11, 1, 32'hB8, 2'b00, 1);
    wait_hs(base + 4, "rr2");
    exp_order[0] = 0; exp_order[1] = 2; exp_order[2] = 5; exp_order[3] = 0;
    check("rr_count", order_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < order_q.size()) check("rr_order", order_q[k], exp_order[k]);
    end
    wait_idle("rr2");

    // routing to M1: DRAM RID 8'h27, 2 beats
    base = hs_cnt;
    load(SLV_DRAM, 8'h27, 2, 32'hC0, 2'b10, 2);
    wait_hs(base + 2, "m1");
    wait_idle("m1");
    check("m1_drained", exp_m1.size(), 0);

    // bad tag: SD RID 8'h85 is sunk, nothing forwarded
    base = hs_cnt;
    load(SLV_SD, 8'h85, 3, 32'hE0, 2'b11, 0);
    for (int c = 0; c < 20 && !busy; c++) begin
      @(posedge clk); #2;
    end
    check("sink_busy", busy, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("sink_rready_s", RREADY_S, 7'h40);
      check("sink_rvalid_m", {RVALID_M0, RVALID_M1}, 2'b00);
    end
    @(posedge clk); #2;
    check("sink_handshakes", hs_cnt - base, 3);
    check("sink_idle", busy, 1'b0);

    // beat counter saturation on a long sunk burst
    base = hs_cnt;
    load(SLV_SD, 8'h85, 300, 32'h0, 2'b00, 0);
    wait_hs(base + 255, "sat255");
    check("sat_255", beat_cnt, 8'd255);
    wait_hs(base + 256, "sat256");
    check("sat_hold", beat_cnt, 8'd255);
    wait_hs(base + 300, "sat_end");
    check("sat_clear", beat_cnt, 8'd0);
    wait_idle("sat");

    repeat (3) @(posedge clk);
    check("final_m0_empty", exp_m0.size(), 0);
    check("final_m1_empty", exp_m1.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
